// File: rtl/cnn_mac_pipe_sat.sv
// cnn_mac_pipe_sat: pipelined signed multiply-accumulate with group framing
// (first/last tags), saturating accumulation and valid/ready on both sides.
// One stall signal (adv) freezes every register when a result is waiting
// for downstream, so no beat is ever dropped or duplicated.
module cnn_mac_pipe_sat #(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 32,
   parameter int NUM_STAGE = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [A_WIDTH-1:0]   din0,
   input  logic signed [B_WIDTH-1:0]   din1,
   input  logic                        in_first,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] dout,
   output logic                        ovf
);

   localparam int PW = A_WIDTH + B_WIDTH;
   localparam int NT = NUM_STAGE - 1;
   localparam int EW = ACC_WIDTH + 1;

   localparam logic signed [EW-1:0] MAX_EXT = {2'b00, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] MIN_EXT = {2'b11, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic adv;

   logic signed [A_WIDTH-1:0] a_d, a_q;
   logic signed [B_WIDTH-1:0] b_d, b_q;
   logic v1_d, v1_q, f1_d, f1_q, l1_d, l1_q;

   logic signed [PW-1:0] a_ext, b_ext, prod;

   logic [NT-1:0][PW-1:0] tap_p;
   logic [NT-1:0]         tap_v, tap_f, tap_l;

   logic [PW-1:0]                p_last;
   logic signed [EW-1:0]         p_ext, acc_ext, sum;
   logic signed [ACC_WIDTH-1:0]  acc_d, acc_q, acc_new, dout_d, dout_q;
   logic                         grp_ovf_d, grp_ovf_q, ovf_new, ovf_d, ovf_q;
   logic                         out_valid_d, out_valid_q;

   // The whole pipeline moves only when the output slot is free or being taken.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Operand stage: capture operands and tags; tags are masked by in_valid.
   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      v1_d = v1_q;
      f1_d = f1_q;
      l1_d = l1_q;
      if (adv) begin
         a_d  = din0;
         b_d  = din1;
         v1_d = in_valid;
         f1_d = in_valid && in_first;
         l1_d = in_valid && in_last;
      end
   end

   // Operand stage registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q  <= '0;
         b_q  <= '0;
         v1_q <= 1'b0;
         f1_q <= 1'b0;
         l1_q <= 1'b0;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         v1_q <= v1_d;
         f1_q <= f1_d;
         l1_q <= l1_d;
      end
   end

   assign a_ext = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q};
   assign b_ext = {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
   assign prod  = a_ext * b_ext;

   assign tap_p[0] = prod;
   assign tap_v[0] = v1_q;
   assign tap_f[0] = f1_q;
   assign tap_l[0] = l1_q;

   for (genvar k = 1; k < NT; k++) begin : g_prod
      logic [PW-1:0] p_d, p_q;
      logic          v_d, v_q, f_d, f_q, l_d, l_q;

      // Product delay stage: shift the product and its tags forward on advance.
      always_comb begin
         p_d = p_q;
         v_d = v_q;
         f_d = f_q;
         l_d = l_q;
         if (adv) begin
            p_d = tap_p[k-1];
            v_d = tap_v[k-1];
            f_d = tap_f[k-1];
            l_d = tap_l[k-1];
         end
      end

      // Product delay stage registers.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            p_q <= '0;
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
         end else begin
            p_q <= p_d;
            v_q <= v_d;
            f_q <= f_d;
            l_q <= l_d;
         end
      end

      assign tap_p[k] = p_q;
      assign tap_v[k] = v_q;
      assign tap_f[k] = f_q;
      assign tap_l[k] = l_q;
   end

   assign p_last  = tap_p[NT-1];
   assign p_ext   = {{(EW-PW){p_last[PW-1]}}, p_last};
   assign acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
   assign sum     = acc_ext + p_ext;

   // Accumulate stage: restart on first, otherwise add with clamping and
   // sticky overflow; a last beat loads the result slot.
   always_comb begin
      acc_d       = acc_q;
      grp_ovf_d   = grp_ovf_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      acc_new     = sum[ACC_WIDTH-1:0];
      ovf_new     = grp_ovf_q;
      if (tap_f[NT-1]) begin
         acc_new = p_ext[ACC_WIDTH-1:0];
         ovf_new = 1'b0;
      end else if (sum > MAX_EXT) begin
         acc_new = ACC_MAX;
         ovf_new = 1'b1;
      end else if (sum < MIN_EXT) begin
         acc_new = ACC_MIN;
         ovf_new = 1'b1;
      end
      if (adv) begin
         out_valid_d = 1'b0;
         if (tap_v[NT-1]) begin
            acc_d     = acc_new;
            grp_ovf_d = ovf_new;
            if (tap_l[NT-1]) begin
               dout_d      = acc_new;
               ovf_d       = ovf_new;
               out_valid_d = 1'b1;
            end
         end
      end
   end

   // Accumulator and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q       <= '0;
         grp_ovf_q   <= 1'b0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         grp_ovf_q   <= grp_ovf_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign dout      = dout_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule
